mem_wb_arbiter: RTL and testbench
=================================

Name: mem_wb_arbiter

Overview:
Two-master Wishbone arbiter that shares the single memory bus between the instruction fetch port (IMEM) and the data load/store port (DMEM).
- Grants are registered. The bus stays locked to one master until that master's cycle completes by ack, abort or timeout.
- Conflicts are resolved round-robin.
- A watchdog counter force-completes hung cycles so the core's stall logic cannot deadlock.
- Sits between the core's memory stages and the memory/peripheral interconnect.

Parameters:
TIMEOUT_CYCLES, 255, cycles a granted cycle may wait for slave ack before forced completion; 0 disables the watchdog
CNT_W, 8, width of the watchdog counter; must satisfy 2**CNT_W > TIMEOUT_CYCLES

Ports:
clk  input  1  system clock, all state on rising edge
nRst  input  1  asynchronous active-low reset
imem_wb  WISHBONE_IF.slave  bundle  request port from the instruction memory interface
dmem_wb  WISHBONE_IF.slave  bundle  request port from the data memory interface
mem_wb  WISHBONE_IF.master  bundle  shared downstream memory bus
oGrant  output  2  one-hot current owner: bit0 = IMEM, bit1 = DMEM, 00 = idle
oBusErr  output  1  one-cycle pulse on watchdog forced completion

Behaviour:
- Clock and reset: one clock (clk); nRst is asynchronous, active-low.
- Request definition: a master requests when cyc & stb.
- Reset values (nRst = 0, takes effect immediately):
  - state = IDLE, last_grant = DMEM, counter = 0.
  - mem_wb.cyc/stb/we = 0, mem_wb.addr = 0, mem_wb.width = eDW_W.
  - Both master acks = 0, oGrant = 00, oBusErr = 0.
- States: IDLE, GNT_I, GNT_D.
- IDLE:
  - Downstream cyc/stb held 0.
  - Only IMEM requests -> GNT_I. Only DMEM requests -> GNT_D.
  - Both request -> grant the master that is not last_grant.
  - None -> stay in IDLE.
  - Arbitration latency: request seen in cycle N, downstream bus driven from cycle N+1.
- GNT_x, combinational routing from the granted master to mem_wb:
  - addr, we, stb, cyc, width, data_write are passed straight through.
  - mem_wb.data_read is broadcast to both masters.
  - ack is routed only to the granted master. The other master's ack is 0, so it stalls.
  - last_grant is updated to x on entry.
- Completion, any of the following returns the block to IDLE on the next cycle:
  - mem_wb.ack = 1 while the granted master's cyc = 1: completion, one mandatory idle bubble before the next grant.
  - Granted master drops cyc before ack: abort. No ack is returned, and a late slave ack in IDLE is ignored.
- Watchdog:
  - Counter clears on grant entry and increments each GNT cycle without ack.
  - When counter == TIMEOUT_CYCLES and TIMEOUT_CYCLES != 0:
    - Assert ack to the granted master for exactly one cycle with data_read forced to 32'h0.
    - Pulse oBusErr for the same cycle.
    - Deassert downstream cyc/stb in that cycle.
    - Go to IDLE.
  - A real ack arriving in the timeout cycle takes precedence: normal completion, no oBusErr.
- Simultaneous events: a request from the non-granted master during a grant is held off until IDLE. Back-to-back conflicting traffic therefore alternates I, D, I, D with one bubble between grants.
- Reset mid-cycle: all state returns to reset values immediately; any in-flight cycle is dropped with no ack.
- oGrant is the registered one-hot state decode.

Test Plan:
1. Reset, then IMEM only reads addr 0x0000_0100, slave acks after 2 cycles with data 0xDEAD_BEEF:
   - oGrant = 01 from cycle 1.
   - imem ack high for 1 cycle with data 0xDEAD_BEEF; dmem ack stays 0.
   - Block is IDLE the cycle after the ack.
2. IMEM and DMEM request in the same cycle straight after reset, slave acks every access in 1 cycle:
   - Grant order is IMEM, then DMEM, then IMEM.
   - oGrant sequence is 01, 00, 10, 00, 01.
3. DMEM write (we = 1, addr 0x2000_0004, data_write 0x1234_5678, width eDW_W) while IMEM also requests:
   - mem_wb carries DMEM's we/addr/data during GNT_D.
   - IMEM sees ack = 0 throughout GNT_D.
4. TIMEOUT_CYCLES = 4, slave never acks an IMEM request:
   - imem ack and oBusErr pulse together in the 5th grant cycle, with data_read = 0.
   - oGrant = 00 on the next cycle.
5. DMEM drops cyc in the 2nd grant cycle, then the slave acks one cycle later:
   - Arbiter returns to IDLE, no ack reaches DMEM, oBusErr = 0.
6. nRst pulled low mid-way through GNT_D:
   - mem_wb.cyc = 0 and oGrant = 00 asynchronously.
   - After release, the first conflicting request is granted to IMEM.

Source files
------------

// File: rtl/mem_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_wb_arbiter
// Purpose  : Round-robin IMEM/DMEM arbiter onto one Wishbone bus, with a
//            watchdog that force-completes hung cycles.
// Revision : 1.0  initial release
// ============================================================================
// Transfer width encoding on *_width: 2'b00 byte, 2'b01 half, 2'b10 word.
module mem_wb_arbiter #(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int CNT_W          = 8
) (
  input  logic        clk,
  input  logic        nRst,
  // instruction fetch master
  input  logic        imem_wb_cyc,
  input  logic        imem_wb_stb,
  input  logic        imem_wb_we,
  input  logic [31:0] imem_wb_addr,
  input  logic [1:0]  imem_wb_width,
  input  logic [31:0] imem_wb_data_write,
  output logic [31:0] imem_wb_data_read,
  output logic        imem_wb_ack,
  // data load/store master
  input  logic        dmem_wb_cyc,
  input  logic        dmem_wb_stb,
  input  logic        dmem_wb_we,
  input  logic [31:0] dmem_wb_addr,
  input  logic [1:0]  dmem_wb_width,
  input  logic [31:0] dmem_wb_data_write,
  output logic [31:0] dmem_wb_data_read,
  output logic        dmem_wb_ack,
  // shared downstream bus
  output logic        mem_wb_cyc,
  output logic        mem_wb_stb,
  output logic        mem_wb_we,
  output logic [31:0] mem_wb_addr,
  output logic [1:0]  mem_wb_width,
  output logic [31:0] mem_wb_data_write,
  input  logic [31:0] mem_wb_data_read,
  input  logic        mem_wb_ack,
  // status
  output logic [1:0]  oGrant,
  output logic        oBusErr
);

  localparam logic [1:0]       c_dw_w     = 2'b10;
  localparam logic [CNT_W-1:0] c_timeout  = CNT_W'(TIMEOUT_CYCLES);
  localparam logic             c_wdog_en  = (TIMEOUT_CYCLES != 0);

  // State values double as the one-hot grant vector.
  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    GNT_I = 2'b01,
    GNT_D = 2'b10
  } state_e;

  state_e             state_q, state_d;
  logic               last_grant_q, last_grant_d;   // 1 = DMEM was last owner
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic               req_i, req_d;
  logic               granted, sel_d;
  logic               gnt_cyc, gnt_stb, gnt_we;
  logic [31:0]        gnt_addr, gnt_wdata;
  logic [1:0]         gnt_width;
  logic               real_ack, timeout;

  assign req_i   = imem_wb_cyc & imem_wb_stb;
  assign req_d   = dmem_wb_cyc & dmem_wb_stb;
  assign granted = (state_q == GNT_I) || (state_q == GNT_D);
  assign sel_d   = (state_q == GNT_D);

  assign gnt_cyc   = sel_d ? dmem_wb_cyc        : imem_wb_cyc;
  assign gnt_stb   = sel_d ? dmem_wb_stb        : imem_wb_stb;
  assign gnt_we    = sel_d ? dmem_wb_we         : imem_wb_we;
  assign gnt_addr  = sel_d ? dmem_wb_addr       : imem_wb_addr;
  assign gnt_width = sel_d ? dmem_wb_width      : imem_wb_width;
  assign gnt_wdata = sel_d ? dmem_wb_data_write : imem_wb_data_write;

  // A slave ack in the timeout cycle wins over the watchdog.
  assign real_ack = granted & gnt_cyc & mem_wb_ack;
  assign timeout  = granted & gnt_cyc & ~mem_wb_ack & c_wdog_en & (cnt_q == c_timeout);

  assign oGrant = state_q;

  always_comb begin
    state_d           = state_q;
    last_grant_d      = last_grant_q;
    cnt_d             = cnt_q;
    mem_wb_cyc        = 1'b0;
    mem_wb_stb        = 1'b0;
    mem_wb_we         = 1'b0;
    mem_wb_addr       = '0;
    mem_wb_width      = c_dw_w;
    mem_wb_data_write = '0;
    imem_wb_ack       = 1'b0;
    dmem_wb_ack       = 1'b0;
    oBusErr           = 1'b0;
    imem_wb_data_read = mem_wb_data_read;
    dmem_wb_data_read = mem_wb_data_read;

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (req_i && (!req_d || last_grant_q)) begin
          state_d      = GNT_I;
          last_grant_d = 1'b0;
        end else if (req_d) begin
          state_d      = GNT_D;
          last_grant_d = 1'b1;
        end
      end

      GNT_I, GNT_D: begin
        mem_wb_cyc        = gnt_cyc & ~timeout;
        mem_wb_stb        = gnt_stb & ~timeout;
        mem_wb_we         = gnt_we;
        mem_wb_addr       = gnt_addr;
        mem_wb_width      = gnt_width;
        mem_wb_data_write = gnt_wdata;
        imem_wb_ack       = ~sel_d & (real_ack | timeout);
        dmem_wb_ack       =  sel_d & (real_ack | timeout);
        oBusErr           = timeout;
        if (timeout) begin
          imem_wb_data_read = '0;
          dmem_wb_data_read = '0;
        end
        // Dropping cyc is an abort: back to idle without any ack.
        if (!gnt_cyc || mem_wb_ack || timeout) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      cnt_q        <= cnt_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_wb_arbiter
// Purpose  : Directed plus randomized self-checking bench for mem_wb_arbiter.
// Revision : 1.0  initial release
// ============================================================================
module tb_mem_wb_arbiter;

  localparam int         TO   = 4;
  localparam logic [1:0] DW_W = 2'b10;

  logic        clk = 1'b0;
  logic        nRst;
  logic        imem_wb_cyc, imem_wb_stb, imem_wb_we, imem_wb_ack;
  logic [31:0] imem_wb_addr, imem_wb_data_write, imem_wb_data_read;
  logic [1:0]  imem_wb_width;
  logic        dmem_wb_cyc, dmem_wb_stb, dmem_wb_we, dmem_wb_ack;
  logic [31:0] dmem_wb_addr, dmem_wb_data_write, dmem_wb_data_read;
  logic [1:0]  dmem_wb_width;
  logic        mem_wb_cyc, mem_wb_stb, mem_wb_we, mem_wb_ack;
  logic [31:0] mem_wb_addr, mem_wb_data_write, mem_wb_data_read;
  logic [1:0]  mem_wb_width;
  logic [1:0]  oGrant;
  logic        oBusErr;

  always #5 clk = ~clk;

  mem_wb_arbiter #(.TIMEOUT_CYCLES(TO), .CNT_W(8)) dut (
    .clk(clk), .nRst(nRst),
    .imem_wb_cyc(imem_wb_cyc), .imem_wb_stb(imem_wb_stb), .imem_wb_we(imem_wb_we),
    .imem_wb_addr(imem_wb_addr), .imem_wb_width(imem_wb_width),
    .imem_wb_data_write(imem_wb_data_write), .imem_wb_data_read(imem_wb_data_read),
    .imem_wb_ack(imem_wb_ack),
    .dmem_wb_cyc(dmem_wb_cyc), .dmem_wb_stb(dmem_wb_stb), .dmem_wb_we(dmem_wb_we),
    .dmem_wb_addr(dmem_wb_addr), .dmem_wb_width(dmem_wb_width),
    .dmem_wb_data_write(dmem_wb_data_write), .dmem_wb_data_read(dmem_wb_data_read),
    .dmem_wb_ack(dmem_wb_ack),
    .mem_wb_cyc(mem_wb_cyc), .mem_wb_stb(mem_wb_stb), .mem_wb_we(mem_wb_we),
    .mem_wb_addr(mem_wb_addr), .mem_wb_width(mem_wb_width),
    .mem_wb_data_write(mem_wb_data_write), .mem_wb_data_read(mem_wb_data_read),
    .mem_wb_ack(mem_wb_ack),
    .oGrant(oGrant), .oBusErr(oBusErr)
  );

  int total = 0;
  int bad   = 0;

  // Stimulus for the current cycle; index 0 = IMEM, 1 = DMEM.
  logic        s_cyc [2];
  logic        s_stb [2];
  logic        s_we  [2];
  logic [31:0] s_addr[2];
  logic [1:0]  s_width[2];
  logic [31:0] s_wdata[2];
  logic        s_ack;
  logic [31:0] s_rdata;

  // Reference model: who owns the bus (0 none, 1 IMEM, 2 DMEM), who owned it
  // last, and how many grant cycles the owner has already waited.
  int   owner, last, waitc;
  int   n_owner, n_last, n_wait;
  logic busy[2];

  logic [1:0]  e_grant, e_width;
  logic        e_ack[2];
  logic        e_err, e_cyc, e_stb, e_we;
  logic [31:0] e_addr, e_wdata, e_rdata;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic apply_stim();
    imem_wb_cyc = s_cyc[0];  imem_wb_stb = s_stb[0];  imem_wb_we = s_we[0];
    imem_wb_addr = s_addr[0]; imem_wb_width = s_width[0]; imem_wb_data_write = s_wdata[0];
    dmem_wb_cyc = s_cyc[1];  dmem_wb_stb = s_stb[1];  dmem_wb_we = s_we[1];
    dmem_wb_addr = s_addr[1]; dmem_wb_width = s_width[1]; dmem_wb_data_write = s_wdata[1];
    mem_wb_ack = s_ack;      mem_wb_data_read = s_rdata;
  endtask

  task automatic clear_stim();
    for (int m = 0; m < 2; m++) begin
      s_cyc[m] = 1'b0; s_stb[m] = 1'b0; s_we[m] = 1'b0;
      s_addr[m] = '0;  s_width[m] = DW_W; s_wdata[m] = '0;
    end
    s_ack = 1'b0; s_rdata = '0;
  endtask

  task automatic model_reset();
    owner = 0; last = 2; waitc = 0;
    busy[0] = 1'b0; busy[1] = 1'b0;
  endtask

  task automatic predict();
    int m;
    bit ri, rd;
    e_grant = 2'b00; e_ack[0] = 1'b0; e_ack[1] = 1'b0; e_err = 1'b0;
    e_cyc = 1'b0; e_stb = 1'b0; e_we = 1'b0; e_addr = '0; e_width = DW_W;
    e_wdata = '0; e_rdata = s_rdata;
    n_owner = owner; n_last = last; n_wait = waitc;
    if (owner == 0) begin
      ri = s_cyc[0] && s_stb[0];
      rd = s_cyc[1] && s_stb[1];
      if (ri && rd)  n_owner = (last == 2) ? 1 : 2;
      else if (ri)   n_owner = 1;
      else if (rd)   n_owner = 2;
      else           n_owner = 0;
      if (n_owner != 0) begin
        n_last = n_owner;
        n_wait = 0;
      end
    end else begin
      m       = owner - 1;
      e_grant = (owner == 1) ? 2'b01 : 2'b10;
      e_cyc   = s_cyc[m];   e_stb   = s_stb[m];   e_we = s_we[m];
      e_addr  = s_addr[m];  e_width = s_width[m]; e_wdata = s_wdata[m];
      if (!s_cyc[m]) begin
        n_owner = 0;
      end else if (s_ack) begin
        e_ack[m] = 1'b1;
        n_owner  = 0;
      end else if (waitc == TO) begin
        e_ack[m] = 1'b1; e_err = 1'b1; e_rdata = '0;
        e_cyc    = 1'b0; e_stb = 1'b0;
        n_owner  = 0;
      end else begin
        n_wait = waitc + 1;
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    apply_stim();
    predict();
    @(negedge clk);
    check("grant",   32'(oGrant),            32'(e_grant));
    check("buserr",  32'(oBusErr),           32'(e_err));
    check("imem_ack", 32'(imem_wb_ack),      32'(e_ack[0]));
    check("dmem_ack", 32'(dmem_wb_ack),      32'(e_ack[1]));
    check("imem_rd", imem_wb_data_read,      e_rdata);
    check("dmem_rd", dmem_wb_data_read,      e_rdata);
    check("mem_cyc", 32'(mem_wb_cyc),        32'(e_cyc));
    check("mem_stb", 32'(mem_wb_stb),        32'(e_stb));
    check("mem_we",  32'(mem_wb_we),         32'(e_we));
    check("mem_addr", mem_wb_addr,           e_addr);
    check("mem_width", 32'(mem_wb_width),    32'(e_width));
    check("mem_wdata", mem_wb_data_write,    e_wdata);
    owner = n_owner; last = n_last; waitc = n_wait;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #2;
    nRst = 1'b0;
    clear_stim();
    apply_stim();
    @(negedge clk);
    nRst = 1'b1;
    model_reset();
  endtask

  task automatic set_req(input int m, input logic we, input logic [31:0] addr,
                         input logic [31:0] wdata);
    s_cyc[m] = 1'b1; s_stb[m] = 1'b1; s_we[m] = we;
    s_addr[m] = addr; s_width[m] = DW_W; s_wdata[m] = wdata;
  endtask

  task automatic rand_cycle(input int ack_pct);
    for (int m = 0; m < 2; m++) begin
      if (busy[m]) begin
        if ($urandom_range(19) == 0) busy[m] = 1'b0;
      end else if ($urandom_range(2) == 0) begin
        busy[m]    = 1'b1;
        s_addr[m]  = $urandom;
        s_we[m]    = 1'($urandom_range(1));
        s_width[m] = 2'($urandom_range(3));
        s_wdata[m] = $urandom;
      end
      s_cyc[m] = busy[m];
      s_stb[m] = busy[m];
      // cyc without stb is not a request
      if (!busy[m] && owner != m + 1 && $urandom_range(7) == 0) s_cyc[m] = 1'b1;
    end
    s_ack   = ($urandom_range(99) < 32'(ack_pct));
    s_rdata = $urandom;
    step();
    for (int m = 0; m < 2; m++) if (e_ack[m]) busy[m] = 1'b0;
  endtask

  int grant_seq[6] = '{0, 1, 0, 2, 0, 1};

  initial begin
    // Reset state with live inputs pushing against it
    nRst = 1'b0;
    clear_stim();
    set_req(0, 1'b0, 32'h0000_0100, 32'h0);
    s_ack = 1'b1; s_rdata = 32'hFFFF_FFFF;
    apply_stim();
    #3;
    check("rst_grant", 32'(oGrant), 32'd0);
    check("rst_cyc",   32'(mem_wb_cyc), 32'd0);
    check("rst_stb",   32'(mem_wb_stb), 32'd0);
    check("rst_we",    32'(mem_wb_we), 32'd0);
    check("rst_addr",  mem_wb_addr, 32'd0);
    check("rst_width", 32'(mem_wb_width), 32'(DW_W));
    check("rst_iack",  32'(imem_wb_ack), 32'd0);
    check("rst_dack",  32'(dmem_wb_ack), 32'd0);
    check("rst_err",   32'(oBusErr), 32'd0);
    clear_stim();
    apply_stim();
    @(negedge clk);
    nRst = 1'b1;
    model_reset();

    // 1: IMEM-only read, ack after two grant cycles
    set_req(0, 1'b0, 32'h0000_0100, 32'h0);
    step();
    check("t1_idle", 32'(oGrant), 32'd0);
    step();
    check("t1_grant", 32'(oGrant), 32'd1);
    s_ack = 1'b1; s_rdata = 32'hDEAD_BEEF;
    step();
    check("t1_iack", 32'(imem_wb_ack), 32'd1);
    check("t1_data", imem_wb_data_read, 32'hDEAD_BEEF);
    check("t1_dack", 32'(dmem_wb_ack), 32'd0);
    clear_stim();
    step();
    check("t1_back_idle", 32'(oGrant), 32'd0);

    // 2: simultaneous requests straight after reset, single-cycle acks
    do_reset();
    set_req(0, 1'b0, 32'h0000_0200, 32'h0);
    set_req(1, 1'b0, 32'h1000_0000, 32'h0);
    s_ack = 1'b1; s_rdata = 32'h0BAD_F00D;
    for (int i = 0; i < 6; i++) begin
      step();
      check("t2_seq", 32'(oGrant), 32'(grant_seq[i]));
    end

    // 3: DMEM write while IMEM waits
    do_reset();
    set_req(1, 1'b1, 32'h2000_0004, 32'h1234_5678);
    step();
    set_req(0, 1'b0, 32'h0000_0300, 32'h0);
    step();
    check("t3_we",    32'(mem_wb_we), 32'd1);
    check("t3_addr",  mem_wb_addr, 32'h2000_0004);
    check("t3_wdata", mem_wb_data_write, 32'h1234_5678);
    check("t3_iack",  32'(imem_wb_ack), 32'd0);
    s_ack = 1'b1;
    step();
    check("t3_dack", 32'(dmem_wb_ack), 32'd1);
    check("t3_iack2", 32'(imem_wb_ack), 32'd0);
    s_cyc[1] = 1'b0; s_stb[1] = 1'b0;
    step();
    step();
    check("t3_then_i", 32'(oGrant), 32'd1);

    // 4: watchdog on an IMEM read that is never acked
    do_reset();
    set_req(0, 1'b0, 32'h0000_0400, 32'h0);
    s_rdata = 32'hA5A5_A5A5;
    step();
    for (int i = 0; i < 5; i++) step();
    check("t4_iack", 32'(imem_wb_ack), 32'd1);
    check("t4_err",  32'(oBusErr), 32'd1);
    check("t4_data", imem_wb_data_read, 32'h0);
    clear_stim();
    step();
    check("t4_idle", 32'(oGrant), 32'd0);

    // 5: DMEM abort followed by a late slave ack
    do_reset();
    set_req(1, 1'b0, 32'h3000_0000, 32'h0);
    step();
    step();
    s_cyc[1] = 1'b0; s_stb[1] = 1'b0;
    step();
    s_ack = 1'b1;
    step();
    check("t5_dack", 32'(dmem_wb_ack), 32'd0);
    check("t5_err",  32'(oBusErr), 32'd0);
    check("t5_idle", 32'(oGrant), 32'd0);

    // 6: asynchronous reset in the middle of a DMEM grant
    do_reset();
    set_req(1, 1'b0, 32'h4000_0000, 32'h0);
    step();
    step();
    check("t6_gnt_d", 32'(oGrant), 32'd2);
    @(posedge clk);
    #3;
    nRst = 1'b0;
    #1;
    check("t6_cyc",   32'(mem_wb_cyc), 32'd0);
    check("t6_grant", 32'(oGrant), 32'd0);
    check("t6_dack",  32'(dmem_wb_ack), 32'd0);
    clear_stim();
    apply_stim();
    @(negedge clk);
    nRst = 1'b1;
    model_reset();
    set_req(0, 1'b0, 32'h0000_0500, 32'h0);
    set_req(1, 1'b0, 32'h4000_0008, 32'h0);
    step();
    step();
    check("t6_first_i", 32'(oGrant), 32'd1);

    // Randomized traffic at several slave responsiveness levels
    do_reset();
    for (int i = 0; i < 400; i++) rand_cycle(45);
    for (int i = 0; i < 400; i++) rand_cycle(8);
    for (int i = 0; i < 400; i++) rand_cycle(85);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
